// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter: CPU vs external requester
// Fixed CPU priority with a starvation guard, plus an exclusive lock mode for burst loading.
module mem_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_gnt,
  output logic              o_cpu_stall,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_ext_req,
  input  logic              i_ext_we,
  input  logic [ADDR_W-1:0] i_ext_addr,
  input  logic [DATA_W-1:0] i_ext_wdata,
  input  logic              i_ext_lock,
  output logic              o_ext_gnt,
  output logic              o_ext_rvalid,
  output logic [DATA_W-1:0] o_ext_rdata,
  output logic              o_locked,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int               CNT_W      = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_CPU_PRI = 2'd0,
    S_EXT_PRI = 2'd1,
    S_LOCK    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_cpu_gnt;
  logic             w_ext_gnt;
  logic             r_cpu_rd;
  logic             r_ext_rd;

  // Grants are suppressed while reset is high so nothing reaches memory mid-reset.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_ext_gnt = 1'b0;
    if (!i_reset) begin
      case (r_state)
        S_CPU_PRI: begin
          w_cpu_gnt = i_cpu_req;
          w_ext_gnt = i_ext_req & ~i_cpu_req;
        end
        S_EXT_PRI: begin
          w_ext_gnt = i_ext_req;
          w_cpu_gnt = i_cpu_req & ~i_ext_req;
        end
        S_LOCK: begin
          w_ext_gnt = i_ext_req;
        end
        default: begin
          w_cpu_gnt = 1'b0;
          w_ext_gnt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_starve_cnt_nxt = r_starve_cnt;
    w_cnt_inc        = (r_starve_cnt == HOLD_LIMIT) ? r_starve_cnt : r_starve_cnt + 1'b1;
    case (r_state)
      S_CPU_PRI: begin
        if (w_ext_gnt || !i_ext_req) begin
          w_starve_cnt_nxt = '0;
        end else if (w_cpu_gnt) begin
          w_starve_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == HOLD_LIMIT) begin
            w_state_nxt = S_EXT_PRI;
          end
        end
      end
      S_EXT_PRI: begin
        if (w_ext_gnt || !i_ext_req) begin
          w_state_nxt      = S_CPU_PRI;
          w_starve_cnt_nxt = '0;
        end
      end
      S_LOCK: begin
        if (!i_ext_lock) begin
          w_state_nxt      = S_CPU_PRI;
          w_starve_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt      = S_CPU_PRI;
        w_starve_cnt_nxt = '0;
      end
    endcase
    // A locking external grant overrides every other transition.
    if (w_ext_gnt && i_ext_lock) begin
      w_state_nxt      = S_LOCK;
      w_starve_cnt_nxt = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_CPU_PRI;
      r_starve_cnt <= '0;
      r_cpu_rd     <= 1'b0;
      r_ext_rd     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_cpu_rd     <= w_cpu_gnt & ~i_cpu_we;
      r_ext_rd     <= w_ext_gnt & ~i_ext_we;
    end
  end

  assign o_cpu_gnt    = w_cpu_gnt;
  assign o_ext_gnt    = w_ext_gnt;
  assign o_cpu_stall  = i_cpu_req & ~w_cpu_gnt & ~i_reset;
  assign o_locked     = (r_state == S_LOCK) & ~i_reset;

  // Read-return routing follows the owner registered at the granting edge.
  assign o_cpu_rvalid = r_cpu_rd & ~i_reset;
  assign o_ext_rvalid = r_ext_rd & ~i_reset;
  assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : '0;
  assign o_ext_rdata  = o_ext_rvalid ? i_mem_rdata : '0;

  assign o_mem_we     = (w_cpu_gnt & i_cpu_we) | (w_ext_gnt & i_ext_we);
  assign o_mem_addr   = w_cpu_gnt ? i_cpu_addr  : (w_ext_gnt ? i_ext_addr  : '0);
  assign o_mem_wdata  = w_cpu_gnt ? i_cpu_wdata : (w_ext_gnt ? i_ext_wdata : '0);

endmodule
